id_stage_fwd: RTL and testbench
===============================

// Module: id_stage_fwd
// PURPOSE
//  Parametrised decode stage: successor to the fixed 32-bit ID stage. Holds the IF/ID pipe register and
//  decodes the MIPS subset (addu/addiu/subu/lw/sw/beq/bne/jal/jr/slt/sltu/sll/srl/sra/lui/and/or/xor/nor).
//  Resolves operands from the register file, N forwarding channels and WB write-through.
//  Detects load-use hazards internally and emits a one-shot branch redirect; sits between IF and EXE.
// PARAMETERS
//  XLEN      32  datapath width; PC and immediates sign-extended to XLEN
//  NUM_FWD   3   forwarding channels; index 0 = youngest (EXE), highest priority
//  RF_AW     5   register address width; register 0 reads as zero
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high reset
//  if_valid       in   1            IF presents an instruction
//  if_pc_plus4    in   XLEN         PC+4 of the presented instruction
//  if_inst        in   32           instruction word
//  id_allow_in    out  1            ID accepts from IF this cycle
//  flush          in   1            cancel the instruction held in ID (later-stage exception)
//  exe_allow_in   in   1            EXE accepts this cycle
//  id_to_exe_valid out 1            ID output valid
//  id_alu_op      out  4            ALU op (shared encoding)
//  id_src1        out  XLEN         resolved operand 1 (sa zero-extended for shifts)
//  id_src2        out  XLEN         resolved operand 2 or immediate
//  id_store_data  out  XLEN         resolved rt, for sw
//  id_dest        out  RF_AW        destination (rd / rt / 31)
//  id_rf_we       out  1            writes the register file
//  id_mem_we      out  1            store
//  id_mem_re      out  1            load
//  id_ri          out  1            reserved/undecoded instruction
//  fwd_valid      in   NUM_FWD      channel carries a valid instruction
//  fwd_we         in   NUM_FWD      channel writes the register file
//  fwd_pending    in   NUM_FWD      channel result not yet available (load in flight)
//  fwd_addr       in   NUM_FWD*RF_AW  channel destinations, packed, channel 0 in LSBs
//  fwd_data       in   NUM_FWD*XLEN   channel results, packed
//  wb_we          in   1            WB write enable
//  wb_addr        in   RF_AW        WB address
//  wb_data        in   XLEN         WB data
//  br_taken       out  1            redirect IF (one-shot)
//  br_target      out  XLEN         redirect target
// BEHAVIOUR
//  Reset: valid=0, br_fired=0; all valid-qualified outputs (id_to_exe_valid, br_taken, id_ri) are 0.
//  Pipe register: loads when if_valid & id_allow_in. Otherwise holds.
//    valid <= if_valid when id_allow_in, else held. flush forces valid <= 0 and wins over loading.
//  ready_go = ~hazard. id_allow_in = ~valid | (ready_go & exe_allow_in). id_to_exe_valid = valid & ready_go & ~flush.
//  Operand resolution, per source, with the source enabled by decode:
//    addr==0 -> 0
//    else lowest-index channel with fwd_valid & fwd_we & addr match
//    else WB write-through (wb_we & addr match)
//    else register file.
//  hazard = valid & some enabled source's selected channel has fwd_pending.
//    A pending channel shadowed by a younger matching channel does not stall.
//  Branch: beq/bne compare, jal, jr evaluated on resolved operands.
//    br_taken = valid & ready_go & ~br_fired & ~flush & taken.
//    br_fired sets when br_taken and clears when a new instruction loads.
//    A stalled-by-EXE branch therefore redirects exactly once.
//  Targets:
//    beq/bne: pc_plus4 + (sext(imm)<<2)
//    jal: {pc_plus4[XLEN-1:28], idx, 2'b00}
//    jr: rs
//  jal: src1 = pc_plus4, src2 = 4, dest = 31, alu add.
//  id_ri: valid & no decode match. The instruction passes with rf_we = mem_we = mem_re = 0.
//  Simultaneous flush & stall: flush wins; valid = 0 next cycle, no redirect.
//  Reset mid-stall: valid and br_fired clear; the pipe register content is don't-care.
// STRUCTURE
//  Shared package/header:
//    opcode and func constants
//    ALU op encodings
//    RF_AW/XLEN defaults
//  Sub-module id_operand_sel (one per source): the priority forward mux plus its pending flag.
//  Register file: existing reg_file, parametrised to XLEN/RF_AW.
// TESTING
//  1. addu r3,r1,r2 with r1=5, r2=7, no forwarding -> src1=5, src2=7, dest=3, rf_we=1, one cycle latency.
//  2. ch0 and ch2 both write r1 (ch0=0x11, ch2=0x22) -> src1=0x11. r0 source with a ch0 match -> 0.
//  3. lw r4 in ch0 with fwd_pending=1, next inst uses r4 -> id_allow_in=0 and no valid output.
//     Pending drops -> issues with the ch0 data.
//  4. beq taken with exe_allow_in=0 for 3 cycles -> br_taken high exactly 1 cycle, target = pc+4+(imm<<2).
//  5. flush during a stalled branch -> valid=0 next cycle, br_taken never asserted.
//  6. Opcode 0x3F -> id_ri=1, rf_we=0, mem_we=0. Reset asserted mid-stall -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants, ALU op encoding and the instruction decoder for the ID stage.
package id_stage_fwd_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned NUM_FWD_DEFAULT = 3;
    localparam int unsigned RF_AW_DEFAULT   = 5;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSlt  = 4'd2,
        AluSltu = 4'd3,
        AluAnd  = 4'd4,
        AluOr   = 4'd5,
        AluXor  = 4'd6,
        AluNor  = 4'd7,
        AluSll  = 4'd8,
        AluSrl  = 4'd9,
        AluSra  = 4'd10,
        AluLui  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        DestRd = 2'd0,
        DestRt = 2'd1,
        Dest31 = 2'd2
    } dest_sel_e;

    typedef struct packed {
        alu_op_e   alu_op;
        logic      rs_en;
        logic      rt_en;
        logic      src1_sa;
        logic      src1_pc;
        logic      src2_imm;
        logic      src2_four;
        dest_sel_e dest_sel;
        logic      rf_we;
        logic      mem_we;
        logic      mem_re;
        logic      is_beq;
        logic      is_bne;
        logic      is_jal;
        logic      is_jr;
        logic      ri;
    } dec_t;

    // Pure instruction decode; source enables gate hazard detection so unused fields never stall.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d.alu_op    = AluAdd;
        d.rs_en     = 1'b0;
        d.rt_en     = 1'b0;
        d.src1_sa   = 1'b0;
        d.src1_pc   = 1'b0;
        d.src2_imm  = 1'b0;
        d.src2_four = 1'b0;
        d.dest_sel  = DestRd;
        d.rf_we     = 1'b0;
        d.mem_we    = 1'b0;
        d.mem_re    = 1'b0;
        d.is_beq    = 1'b0;
        d.is_bne    = 1'b0;
        d.is_jal    = 1'b0;
        d.is_jr     = 1'b0;
        d.ri        = 1'b0;
        case (inst[31:26])
            OP_SPECIAL: begin
                d.rs_en = 1'b1;
                d.rt_en = 1'b1;
                d.rf_we = 1'b1;
                case (inst[5:0])
                    FN_ADDU: d.alu_op = AluAdd;
                    FN_SUBU: d.alu_op = AluSub;
                    FN_SLT:  d.alu_op = AluSlt;
                    FN_SLTU: d.alu_op = AluSltu;
                    FN_AND:  d.alu_op = AluAnd;
                    FN_OR:   d.alu_op = AluOr;
                    FN_XOR:  d.alu_op = AluXor;
                    FN_NOR:  d.alu_op = AluNor;
                    FN_SLL: begin
                        d.alu_op  = AluSll;
                        d.rs_en   = 1'b0;
                        d.src1_sa = 1'b1;
                    end
                    FN_SRL: begin
                        d.alu_op  = AluSrl;
                        d.rs_en   = 1'b0;
                        d.src1_sa = 1'b1;
                    end
                    FN_SRA: begin
                        d.alu_op  = AluSra;
                        d.rs_en   = 1'b0;
                        d.src1_sa = 1'b1;
                    end
                    FN_JR: begin
                        d.rt_en = 1'b0;
                        d.rf_we = 1'b0;
                        d.is_jr = 1'b1;
                    end
                    default: begin
                        d.rs_en = 1'b0;
                        d.rt_en = 1'b0;
                        d.rf_we = 1'b0;
                        d.ri    = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                d.rs_en    = 1'b1;
                d.src2_imm = 1'b1;
                d.dest_sel = DestRt;
                d.rf_we    = 1'b1;
            end
            OP_LUI: begin
                d.alu_op   = AluLui;
                d.src2_imm = 1'b1;
                d.dest_sel = DestRt;
                d.rf_we    = 1'b1;
            end
            OP_LW: begin
                d.rs_en    = 1'b1;
                d.src2_imm = 1'b1;
                d.dest_sel = DestRt;
                d.rf_we    = 1'b1;
                d.mem_re   = 1'b1;
            end
            OP_SW: begin
                d.rs_en    = 1'b1;
                d.rt_en    = 1'b1;
                d.src2_imm = 1'b1;
                d.mem_we   = 1'b1;
            end
            OP_BEQ: begin
                d.alu_op = AluSub;
                d.rs_en  = 1'b1;
                d.rt_en  = 1'b1;
                d.is_beq = 1'b1;
            end
            OP_BNE: begin
                d.alu_op = AluSub;
                d.rs_en  = 1'b1;
                d.rt_en  = 1'b1;
                d.is_bne = 1'b1;
            end
            OP_JAL: begin
                d.src1_pc   = 1'b1;
                d.src2_four = 1'b1;
                d.dest_sel  = Dest31;
                d.rf_we     = 1'b1;
                d.is_jal    = 1'b1;
            end
            default: d.ri = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_operand_sel.sv
// Priority operand mux for one source: r0, forwarding channels (lowest index wins), WB, RF.
module id_operand_sel #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned RF_AW   = 5
) (
    input  logic                     en_i,
    input  logic [RF_AW-1:0]         addr_i,
    input  logic [XLEN-1:0]          rf_data_i,
    input  logic [NUM_FWD-1:0]       fwd_valid_i,
    input  logic [NUM_FWD-1:0]       fwd_we_i,
    input  logic [NUM_FWD-1:0]       fwd_pending_i,
    input  logic [NUM_FWD*RF_AW-1:0] fwd_addr_i,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data_i,
    input  logic                     wb_we_i,
    input  logic [RF_AW-1:0]         wb_addr_i,
    input  logic [XLEN-1:0]          wb_data_i,
    output logic [XLEN-1:0]          data_o,
    output logic                     pending_o
);

    logic pend;

    // Walk oldest to youngest so the youngest match overrides, including its pending flag.
    always_comb begin
        data_o = rf_data_i;
        pend   = 1'b0;
        if (wb_we_i && (wb_addr_i == addr_i)) begin
            data_o = wb_data_i;
        end
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && fwd_we_i[i] && (fwd_addr_i[i*RF_AW +: RF_AW] == addr_i)) begin
                data_o = fwd_data_i[i*XLEN +: XLEN];
                pend   = fwd_pending_i[i];
            end
        end
        if (addr_i == '0) begin
            data_o = '0;
            pend   = 1'b0;
        end
    end

    assign pending_o = en_i & pend;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file; register 0 reads as zero and ignores writes.
module reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [RF_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [RF_AW-1:0] raddr1_i,
    output logic [XLEN-1:0]  rdata1_o,
    input  logic [RF_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]  rdata2_o
);

    logic [XLEN-1:0] mem_q [2**RF_AW];

    // Synchronous write port
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: IF/ID pipe register, decode, forwarded operand resolution, load-use stall and
// one-shot branch redirect.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned NUM_FWD = NUM_FWD_DEFAULT,
    parameter int unsigned RF_AW   = RF_AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc_plus4,
    input  logic [31:0]              if_inst,
    output logic                     id_allow_in,
    input  logic                     flush,
    input  logic                     exe_allow_in,
    output logic                     id_to_exe_valid,
    output logic [3:0]               id_alu_op,
    output logic [XLEN-1:0]          id_src1,
    output logic [XLEN-1:0]          id_src2,
    output logic [XLEN-1:0]          id_store_data,
    output logic [RF_AW-1:0]         id_dest,
    output logic                     id_rf_we,
    output logic                     id_mem_we,
    output logic                     id_mem_re,
    output logic                     id_ri,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic [NUM_FWD-1:0]       fwd_pending,
    input  logic [NUM_FWD*RF_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
    input  logic                     wb_we,
    input  logic [RF_AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     br_taken,
    output logic [XLEN-1:0]          br_target
);

    logic            valid_q, valid_d;
    logic            br_fired_q, br_fired_d;
    logic [XLEN-1:0] pc4_q;
    logic [31:0]     inst_q;

    dec_t             dec;
    logic [RF_AW-1:0] rs_addr, rt_addr, rd_addr;
    logic [4:0]       sa;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  rf_rs, rf_rt, rs_val, rt_val;
    logic             rs_pend, rt_pend;
    logic             hazard, ready_go, load, taken;

    assign dec      = decode(inst_q);
    assign rs_addr  = RF_AW'(inst_q[25:21]);
    assign rt_addr  = RF_AW'(inst_q[20:16]);
    assign rd_addr  = RF_AW'(inst_q[15:11]);
    assign sa       = inst_q[10:6];
    assign imm_sext = {{(XLEN-16){inst_q[15]}}, inst_q[15:0]};

    reg_file #(
        .XLEN  (XLEN),
        .RF_AW (RF_AW)
    ) u_rf (
        .clk_i    (clk),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs_addr),
        .rdata1_o (rf_rs),
        .raddr2_i (rt_addr),
        .rdata2_o (rf_rt)
    );

    id_operand_sel #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RF_AW   (RF_AW)
    ) u_sel_rs (
        .en_i          (dec.rs_en),
        .addr_i        (rs_addr),
        .rf_data_i     (rf_rs),
        .fwd_valid_i   (fwd_valid),
        .fwd_we_i      (fwd_we),
        .fwd_pending_i (fwd_pending),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .data_o        (rs_val),
        .pending_o     (rs_pend)
    );

    id_operand_sel #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RF_AW   (RF_AW)
    ) u_sel_rt (
        .en_i          (dec.rt_en),
        .addr_i        (rt_addr),
        .rf_data_i     (rf_rt),
        .fwd_valid_i   (fwd_valid),
        .fwd_we_i      (fwd_we),
        .fwd_pending_i (fwd_pending),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .data_o        (rt_val),
        .pending_o     (rt_pend)
    );

    assign hazard      = valid_q & (rs_pend | rt_pend);
    assign ready_go    = ~hazard;
    assign id_allow_in = ~valid_q | (ready_go & exe_allow_in);
    assign load        = if_valid & id_allow_in & ~flush;

    // Handshake next state: flush beats loading; a fresh instruction re-arms the redirect.
    always_comb begin
        valid_d = valid_q;
        if (id_allow_in) begin
            valid_d = if_valid;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
        br_fired_d = br_fired_q | br_taken;
        if (load) begin
            br_fired_d = 1'b0;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            br_fired_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            br_fired_q <= br_fired_d;
        end
    end

    // Pipe register payload; content is meaningless while valid_q is low
    always_ff @(posedge clk) begin
        if (load) begin
            pc4_q  <= if_pc_plus4;
            inst_q <= if_inst;
        end
    end

    // Branch resolution and target selection on resolved operands
    always_comb begin
        taken = (dec.is_beq && (rs_val == rt_val)) || (dec.is_bne && (rs_val != rt_val)) ||
                dec.is_jal || dec.is_jr;
        if (dec.is_jr) begin
            br_target = rs_val;
        end else if (dec.is_jal) begin
            br_target = {pc4_q[XLEN-1:28], inst_q[25:0], 2'b00};
        end else begin
            br_target = pc4_q + {imm_sext[XLEN-3:0], 2'b00};
        end
    end

    // Operand and destination selection for EXE
    always_comb begin
        if (dec.src1_sa) begin
            id_src1 = {{(XLEN-5){1'b0}}, sa};
        end else if (dec.src1_pc) begin
            id_src1 = pc4_q;
        end else begin
            id_src1 = rs_val;
        end
        if (dec.src2_imm) begin
            id_src2 = imm_sext;
        end else if (dec.src2_four) begin
            id_src2 = XLEN'(32'd4);
        end else begin
            id_src2 = rt_val;
        end
        unique case (dec.dest_sel)
            DestRd:  id_dest = rd_addr;
            DestRt:  id_dest = rt_addr;
            default: id_dest = RF_AW'(5'd31);
        endcase
    end

    assign id_alu_op       = dec.alu_op;
    assign id_store_data   = rt_val;
    assign id_to_exe_valid = valid_q & ready_go & ~flush;
    assign id_rf_we        = valid_q & dec.rf_we;
    assign id_mem_we       = valid_q & dec.mem_we;
    assign id_mem_re       = valid_q & dec.mem_re;
    assign id_ri           = valid_q & dec.ri;
    assign br_taken        = valid_q & ready_go & ~br_fired_q & ~flush & taken;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: decode, forwarding priority, load-use stall, redirects,
// flush and reset behaviour.
module tb_id_stage_fwd;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_inst;
    logic        id_allow_in;
    logic        flush;
    logic        exe_allow_in;
    logic        id_to_exe_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_src1, id_src2, id_store_data;
    logic [4:0]  id_dest;
    logic        id_rf_we, id_mem_we, id_mem_re, id_ri;
    logic [2:0]  fwd_valid, fwd_we, fwd_pending;
    logic [14:0] fwd_addr;
    logic [95:0] fwd_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br_taken;
    logic [31:0] br_target;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage_fwd #(
        .XLEN    (32),
        .NUM_FWD (3),
        .RF_AW   (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_valid        (if_valid),
        .if_pc_plus4     (if_pc_plus4),
        .if_inst         (if_inst),
        .id_allow_in     (id_allow_in),
        .flush           (flush),
        .exe_allow_in    (exe_allow_in),
        .id_to_exe_valid (id_to_exe_valid),
        .id_alu_op       (id_alu_op),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_store_data   (id_store_data),
        .id_dest         (id_dest),
        .id_rf_we        (id_rf_we),
        .id_mem_we       (id_mem_we),
        .id_mem_re       (id_mem_re),
        .id_ri           (id_ri),
        .fwd_valid       (fwd_valid),
        .fwd_we          (fwd_we),
        .fwd_pending     (fwd_pending),
        .fwd_addr        (fwd_addr),
        .fwd_data        (fwd_data),
        .wb_we           (wb_we),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .br_taken        (br_taken),
        .br_target       (br_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [31:0] pc4, input logic [31:0] inst);
        if_valid    = 1'b1;
        if_pc_plus4 = pc4;
        if_inst     = inst;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic we, input logic pend,
                          input logic [4:0] a, input logic [31:0] d);
        fwd_valid[ch]        = v;
        fwd_we[ch]           = we;
        fwd_pending[ch]      = pend;
        fwd_addr[ch*5 +: 5]  = a;
        fwd_data[ch*32 +: 32] = d;
    endtask

    task automatic clear_fwd();
        fwd_valid   = '0;
        fwd_we      = '0;
        fwd_pending = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset        = 1'b1;
        if_valid     = 1'b0;
        if_pc_plus4  = '0;
        if_inst      = '0;
        flush        = 1'b0;
        exe_allow_in = 1'b1;
        wb_we        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        clear_fwd();
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(id_to_exe_valid), 32'd0);
        check("rst_br", 32'(br_taken), 32'd0);
        check("rst_ri", 32'(id_ri), 32'd0);
        check("rst_allow", 32'(id_allow_in), 32'd1);
        reset = 1'b0;

        // Preload r1=5, r2=7, r5=0x100 via the WB port
        wb_we = 1'b1;
        wb_addr = 5'd1; wb_data = 32'd5;     tick();
        wb_addr = 5'd2; wb_data = 32'd7;     tick();
        wb_addr = 5'd5; wb_data = 32'h100;   tick();
        wb_we = 1'b0;

        // 1: addu r3,r1,r2 from the register file
        present(32'h1004, r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        settle();
        check("t1_allow", 32'(id_allow_in), 32'd1);
        check("t1_pre_valid", 32'(id_to_exe_valid), 32'd0);
        tick();
        if_valid = 1'b0;
        settle();
        check("t1_valid", 32'(id_to_exe_valid), 32'd1);
        check("t1_src1", id_src1, 32'd5);
        check("t1_src2", id_src2, 32'd7);
        check("t1_dest", 32'(id_dest), 32'd3);
        check("t1_rf_we", 32'(id_rf_we), 32'd1);
        check("t1_alu", 32'(id_alu_op), 32'd0);
        check("t1_mem_re", 32'(id_mem_re), 32'd0);

        // 2: forwarding priority and WB write-through on addu r6,r1,r2
        present(32'h1008, r_type(5'd1, 5'd2, 5'd6, 5'd0, 6'h21));
        tick();
        if_valid = 1'b0;
        set_ch(0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h11);
        set_ch(1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h33);
        set_ch(2, 1'b1, 1'b1, 1'b0, 5'd1, 32'h22);
        settle();
        check("t2_ch0_wins", id_src1, 32'h11);
        check("t2_ch1_rt", id_src2, 32'h33);
        fwd_valid[0] = 1'b0;
        settle();
        check("t2_ch2_when_ch0_invalid", id_src1, 32'h22);
        fwd_we[2] = 1'b0;
        settle();
        check("t2_rf_when_no_we", id_src1, 32'd5);
        clear_fwd();
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h77;
        settle();
        check("t2_wb_through", id_src2, 32'h77);
        wb_we = 1'b0;
        settle();
        check("t2_rf_rt", id_src2, 32'd7);

        // 2b: r0 source ignores a matching, even pending, channel
        present(32'h100C, r_type(5'd0, 5'd2, 5'd7, 5'd0, 6'h21));
        tick();
        if_valid = 1'b0;
        set_ch(0, 1'b1, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        settle();
        check("t2_r0_zero", id_src1, 32'd0);
        check("t2_r0_no_stall", 32'(id_to_exe_valid), 32'd1);
        clear_fwd();

        // lw r4,8(r1) and sw r2,-4(r1)
        present(32'h1010, i_type(6'h23, 5'd1, 5'd4, 16'h0008));
        tick();
        if_valid = 1'b0;
        settle();
        check("lw_src1", id_src1, 32'd5);
        check("lw_src2", id_src2, 32'd8);
        check("lw_dest", 32'(id_dest), 32'd4);
        check("lw_mem_re", 32'(id_mem_re), 32'd1);
        check("lw_mem_we", 32'(id_mem_we), 32'd0);
        present(32'h1014, i_type(6'h2B, 5'd1, 5'd2, 16'hFFFC));
        tick();
        if_valid = 1'b0;
        settle();
        check("sw_mem_we", 32'(id_mem_we), 32'd1);
        check("sw_rf_we", 32'(id_rf_we), 32'd0);
        check("sw_store", id_store_data, 32'd7);
        check("sw_imm", id_src2, 32'hFFFF_FFFC);

        // 3: load-use stall on addu r8,r4,r2 with ch0 pending on r4
        present(32'h1018, r_type(5'd4, 5'd2, 5'd8, 5'd0, 6'h21));
        set_ch(0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0);
        tick();
        present(32'h101C, r_type(5'd1, 5'd2, 5'd9, 5'd0, 6'h21));
        settle();
        check("t3_allow", 32'(id_allow_in), 32'd0);
        check("t3_valid", 32'(id_to_exe_valid), 32'd0);
        tick();
        check("t3_hold_allow", 32'(id_allow_in), 32'd0);
        check("t3_hold_dest", 32'(id_dest), 32'd8);
        set_ch(0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h44);
        settle();
        check("t3_release_valid", 32'(id_to_exe_valid), 32'd1);
        check("t3_release_src1", id_src1, 32'h44);
        check("t3_release_allow", 32'(id_allow_in), 32'd1);
        tick();
        if_valid = 1'b0;
        clear_fwd();
        settle();
        check("t3_next_dest", 32'(id_dest), 32'd9);
        check("t3_next_src1", id_src1, 32'd5);

        // 3b: pending ch1 shadowed by non-pending ch0 does not stall
        present(32'h1020, r_type(5'd4, 5'd2, 5'd10, 5'd0, 6'h21));
        tick();
        if_valid = 1'b0;
        set_ch(0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h55);
        set_ch(1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h66);
        settle();
        check("t3_shadow_valid", 32'(id_to_exe_valid), 32'd1);
        check("t3_shadow_src1", id_src1, 32'h55);
        fwd_valid[0] = 1'b0;
        settle();
        check("t3_unshadow_stall", 32'(id_allow_in), 32'd0);
        clear_fwd();
        tick();

        // 4: beq r1,r1,+3 held by EXE for 3 cycles fires once
        present(32'h2000, i_type(6'h04, 5'd1, 5'd1, 16'h0003));
        tick();
        if_valid = 1'b0;
        exe_allow_in = 1'b0;
        settle();
        check("t4_br_c0", 32'(br_taken), 32'd1);
        check("t4_target", br_target, 32'h200C);
        check("t4_allow", 32'(id_allow_in), 32'd0);
        tick();
        check("t4_br_c1", 32'(br_taken), 32'd0);
        check("t4_valid_c1", 32'(id_to_exe_valid), 32'd1);
        tick();
        check("t4_br_c2", 32'(br_taken), 32'd0);
        exe_allow_in = 1'b1;
        present(32'h3000, i_type(6'h05, 5'd1, 5'd2, 16'hFFFE));
        settle();
        check("t4_br_c3", 32'(br_taken), 32'd0);
        tick();
        if_valid = 1'b0;
        settle();
        check("t4_bne_taken", 32'(br_taken), 32'd1);
        check("t4_bne_target", br_target, 32'h2FF8);

        // bne not taken, jal, jr
        present(32'h3004, i_type(6'h05, 5'd1, 5'd1, 16'h0010));
        tick();
        if_valid = 1'b0;
        settle();
        check("bne_not_taken", 32'(br_taken), 32'd0);
        present(32'h3000_0004, {6'h03, 26'h40});
        tick();
        if_valid = 1'b0;
        settle();
        check("jal_taken", 32'(br_taken), 32'd1);
        check("jal_target", br_target, 32'h3000_0100);
        check("jal_src1", id_src1, 32'h3000_0004);
        check("jal_src2", id_src2, 32'd4);
        check("jal_dest", 32'(id_dest), 32'd31);
        present(32'h4000, r_type(5'd5, 5'd0, 5'd0, 5'd0, 6'h08));
        tick();
        if_valid = 1'b0;
        settle();
        check("jr_taken", 32'(br_taken), 32'd1);
        check("jr_target", br_target, 32'h100);
        check("jr_rf_we", 32'(id_rf_we), 32'd0);

        // 5: flush during an EXE-stalled branch
        present(32'h5000, i_type(6'h04, 5'd1, 5'd1, 16'h0001));
        tick();
        if_valid = 1'b0;
        exe_allow_in = 1'b0;
        flush = 1'b1;
        settle();
        check("t5_br_flush", 32'(br_taken), 32'd0);
        check("t5_valid_flush", 32'(id_to_exe_valid), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        check("t5_valid_after", 32'(id_to_exe_valid), 32'd0);
        check("t5_br_after", 32'(br_taken), 32'd0);
        check("t5_allow_after", 32'(id_allow_in), 32'd1);
        exe_allow_in = 1'b1;

        // 6: reserved opcode passes without side effects
        present(32'h6000, 32'hFC00_0000);
        tick();
        if_valid = 1'b0;
        settle();
        check("t6_ri", 32'(id_ri), 32'd1);
        check("t6_valid", 32'(id_to_exe_valid), 32'd1);
        check("t6_rf_we", 32'(id_rf_we), 32'd0);
        check("t6_mem_we", 32'(id_mem_we), 32'd0);
        check("t6_mem_re", 32'(id_mem_re), 32'd0);

        // Reset during a load-use stall
        present(32'h6004, r_type(5'd4, 5'd2, 5'd8, 5'd0, 6'h21));
        set_ch(0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0);
        tick();
        if_valid = 1'b0;
        settle();
        check("t6_stalled", 32'(id_allow_in), 32'd0);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(id_to_exe_valid), 32'd0);
        check("t6_rst_br", 32'(br_taken), 32'd0);
        check("t6_rst_ri", 32'(id_ri), 32'd0);
        check("t6_rst_rf_we", 32'(id_rf_we), 32'd0);
        check("t6_rst_allow", 32'(id_allow_in), 32'd1);
        reset = 1'b0;
        clear_fwd();
        tick();
        check("t6_no_stale", 32'(id_to_exe_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
